// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 initiator.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DRAIN
  } spi_state_t;

  localparam int SAMPLE_DLY_W = 4;
  localparam int SPI_DLY_MAX  = 15;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_strobe_delay.sv
// Delays the sclk rise strobe by 0..SPI_DLY_MAX clk cycles to time miso capture.
module spi_strobe_delay
  import spi_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rise,
  input  logic [SAMPLE_DLY_W-1:0] sample_dly,
  output logic                    strobe
);

  logic [SPI_DLY_MAX-1:0] line;
  logic [SPI_DLY_MAX:0]   taps;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) line <= '0;
    else     line <= {line[SPI_DLY_MAX-2:0], rise};
  end

  // Tap 0 is the live strobe, so a zero delay captures in the rise cycle itself.
  assign taps   = {line, rise};
  assign strobe = taps[sample_dly];

endmodule

// File: rtl/spi_initiator.sv
// SPI mode-0 initiator: one DATA_W-bit MSB-first transfer per accepted start,
// with a per-transfer miso capture delay that absorbs the bus round trip.
//
// state | meaning
// IDLE  | cs high, sclk low, waiting for start
// SETUP | cs low, sclk low for CS_SETUP cycles
// SHIFT | per bit: CLK_DIV cycles sclk low, then CLK_DIV cycles sclk high
// HOLD  | cs low, sclk low for CS_HOLD cycles after the last fall
// DRAIN | wait for every delayed capture strobe; done pulses on exit
module spi_initiator
  import spi_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_W-1:0]       tx_data,
  input  logic [SAMPLE_DLY_W-1:0] sample_dly,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_W-1:0]       rx_data,
  output logic                    sclk,
  output logic                    cs,
  output logic                    mosi,
  input  logic                    miso
);

  localparam int CNT_W = $clog2(max3(CLK_DIV, CS_SETUP, CS_HOLD) + 1);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int CAP_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
  localparam logic [BIT_W-1:0] BIT_LD   = BIT_W'(DATA_W - 1);
  localparam logic [CAP_W-1:0] CAP_ALL  = CAP_W'(DATA_W);

  spi_state_t              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [CAP_W-1:0]        cap_q, cap_d;
  logic [DATA_W-1:0]       tx_q, tx_d;
  logic [DATA_W-1:0]       rx_q, rx_d;
  logic [DATA_W-1:0]       rxd_q, rxd_d;
  logic [SAMPLE_DLY_W-1:0] dly_q, dly_d;
  logic                    sclk_q, sclk_d;
  logic                    cs_q, cs_d;
  logic                    mosi_q, mosi_d;
  logic                    rise;
  logic                    strobe;

  // First high cycle of each bit.
  assign rise = (state_q == SHIFT) && sclk_q && (cnt_q == DIV_LD);

  spi_strobe_delay u_dly (
    .clk       (clk),
    .rst       (rst),
    .rise      (rise),
    .sample_dly(dly_q),
    .strobe    (strobe)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      cap_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rxd_q   <= '0;
      dly_q   <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      cap_q   <= cap_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxd_q   <= rxd_d;
      dly_q   <= dly_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    cap_d   = cap_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxd_d   = rxd_q;
    dly_d   = dly_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    done    = 1'b0;

    if (strobe && (state_q != IDLE)) begin
      rx_d  = {rx_q[DATA_W-2:0], miso};
      cap_d = cap_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          cs_d    = 1'b0;
          mosi_d  = tx_data[DATA_W-1];
          tx_d    = {tx_data[DATA_W-2:0], 1'b0};
          dly_d   = sample_dly;
          cap_d   = '0;
          rx_d    = '0;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = SHIFT;
          cnt_d   = DIV_LD;
          bit_d   = BIT_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
          cnt_d  = DIV_LD;
        end else begin
          sclk_d = 1'b0;
          if (bit_q == '0) begin
            mosi_d  = 1'b0;
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            bit_d  = bit_q - 1'b1;
            mosi_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            cnt_d  = DIV_LD;
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = DRAIN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DRAIN: begin
        // cap_d already includes a strobe firing in this very cycle.
        if (cap_d == CAP_ALL) begin
          done    = 1'b1;
          cs_d    = 1'b1;
          rxd_d   = rx_d;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign sclk    = sclk_q;
  assign cs      = cs_q;
  assign mosi    = mosi_q;
  assign rx_data = rxd_q;

endmodule
